pgm_loader: RTL and testbench

- Writer side of the core's program memory.
- Accepts a host stream of 16-bit half-words over a valid/ready handshake and assembles them into 32-bit instructions.
- Writes the instructions into a 16-entry program memory and exposes an asynchronous read port that the core fetches from.
- Holds the core in reset until a load completes cleanly, then releases it.

---
 rtl/pgm_loader_if.sv | 11 +
 rtl/pgm_loader.sv | 141 ++++++++++++++
 tb/tb_pgm_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pgm_loader_if.sv
// Host half-word stream into the program loader: valid/ready handshake.
interface pgm_loader_if #(
  parameter int BW = 16
);
  logic [BW-1:0] ld_data;
  logic          ld_valid;
  logic          ld_ready;

  modport master (output ld_data, output ld_valid, input ld_ready);
  modport slave  (input ld_data, input ld_valid, output ld_ready);
endinterface

// File: rtl/pgm_loader.sv
// Program memory writer: packs host half-words (high first) into instructions and
// holds the core in reset until a load completes. Optional trailer check: PGM_CHECKSUM_EN.
module pgm_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 32,
  parameter int BW    = 16
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          load_start,
  input  logic [AW:0]   load_count,
  pgm_loader_if.slave   ld,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_data,
  output logic          core_rst,
  output logic          done,
  output logic          err,
  output logic [AW:0]   wr_ptr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV_HI,
    S_RECV_LO,
`ifdef PGM_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [BW-1:0] hi_buf_q, hi_buf_d;
  logic          ready;
  logic          mem_we;
  logic [IW-1:0] mem [DEPTH];
`ifdef PGM_CHECKSUM_EN
  logic [BW-1:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    hi_buf_d = hi_buf_q;
    mem_we   = 1'b0;
    ready    = 1'b0;
`ifdef PGM_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_RECV_HI: begin
        ready = 1'b1;
        if (ld.ld_valid) begin
          hi_buf_d = ld.ld_data;
          state_d  = S_RECV_LO;
`ifdef PGM_CHECKSUM_EN
          csum_d   = csum_q ^ ld.ld_data;
`endif
        end
      end
      S_RECV_LO: begin
        ready = 1'b1;
        if (ld.ld_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
`ifdef PGM_CHECKSUM_EN
          csum_d   = csum_q ^ ld.ld_data;
          state_d  = (wr_ptr_d == count_q) ? S_CHK : S_RECV_HI;
`else
          state_d  = (wr_ptr_d == count_q) ? S_DONE : S_RECV_HI;
`endif
        end
      end
`ifdef PGM_CHECKSUM_EN
      S_CHK: begin
        ready = 1'b1;
        if (ld.ld_valid) begin
          state_d = (ld.ld_data == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: begin
        // IDLE, DONE and ERR are the only states that accept a new load
        if (load_start) begin
          if ((load_count != '0) && (load_count <= DEPTH_C)) begin
            count_d  = load_count;
            wr_ptr_d = '0;
            state_d  = S_RECV_HI;
`ifdef PGM_CHECKSUM_EN
            csum_d   = '0;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      hi_buf_q <= '0;
`ifdef PGM_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      hi_buf_q <= hi_buf_d;
`ifdef PGM_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Contents survive reset so a half-finished load leaves earlier words intact
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= {hi_buf_q, ld.ld_data};
    end
  end

  assign rd_data     = mem[rd_addr];
  assign ld.ld_ready = ready;
  assign core_rst    = (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign err         = (state_q == S_ERR);
  assign wr_ptr      = wr_ptr_q;

endmodule

// File: tb/tb_pgm_loader.sv
// Bench for pgm_loader: start-condition table, directed loads and random loads vs a memory model.
module tb_pgm_loader;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 32;
  localparam int BW    = 16;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          load_start;
  logic [AW:0]   load_count;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;
  logic          core_rst;
  logic          done;
  logic          err;
  logic [AW:0]   wr_ptr;

  always #5 clk = ~clk;

  pgm_loader_if #(.BW(BW)) ld_if ();

  pgm_loader #(.DEPTH(DEPTH), .AW(AW), .IW(IW), .BW(BW)) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .load_start (load_start),
    .load_count (load_count),
    .ld         (ld_if),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err),
    .wr_ptr     (wr_ptr)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [DEPTH];
  bit          model_vld [DEPTH];
  logic [15:0] halves [0:32];

  typedef struct {
    logic [4:0] cnt;
    logic       exp_ready;
    logic       exp_err;
    logic       exp_core_rst;
  } start_vec_t;

  start_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_mem();
    for (int i = 0; i < DEPTH; i++) begin
      if (model_vld[i]) begin
        rd_addr = i[AW-1:0];
        #1;
        check($sformatf("rd_data[%0d]", i), rd_data, model_mem[i]);
      end
    end
  endtask

  task automatic pulse_start(input logic [4:0] c);
    @(negedge clk);
    load_start = 1'b1;
    load_count = c;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
  endtask

  // mode: 0 valid always high, 1 valid toggles 1,0,1,0..., 2 random valid
  task automatic run_load(input int count, input int mode, input int nsend, input logic [15:0] flip);
    int nh, nh_tot, limit, sent, n, first_n;
    bit v, expect_ok;
    logic [15:0] x;
    nh = 2 * count;
    x  = 16'h0;
    for (int i = 0; i < nh; i++) x ^= halves[i];
    expect_ok = 1'b1;
`ifdef PGM_CHECKSUM_EN
    halves[nh] = x ^ flip;
    nh_tot     = nh + 1;
    expect_ok  = (flip == 16'h0);
`else
    nh_tot = nh;
`endif
    limit = (nsend < nh_tot) ? nsend : nh_tot;
    $display("load count=%0d mode=%0d halves=%0d flip=0x%0h", count, mode, limit, flip);
    pulse_start(count[4:0]);
    sent = 0; n = 0; first_n = -1;
    while (sent < limit && n < 1000) begin
      check("wr_ptr_step", wr_ptr, (sent > nh ? nh : sent) / 2);
      check("ld_ready_recv", ld_if.ld_ready, 1);
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      ld_if.ld_valid = v;
      ld_if.ld_data  = v ? halves[sent] : 16'($urandom);
      if (v) begin
        if (first_n < 0) first_n = n;
        sent++;
        if (sent == nh_tot) check("done_early", done, 0);
      end
      n++;
      @(negedge clk);
    end
    ld_if.ld_valid = 1'b0;
    if (n >= 1000) check("load_timeout", 1, 0);
    for (int i = 0; i < count && 2 * i + 1 < limit; i++) begin
      model_mem[i] = {halves[2 * i], halves[2 * i + 1]};
      model_vld[i] = 1'b1;
    end
    if (limit == nh_tot) begin
      if (expect_ok) begin
        check("done", done, 1);
        check("core_rst_released", core_rst, 0);
        check("err_clear", err, 0);
        check("wr_ptr_final", wr_ptr, count);
        check("ld_ready_done", ld_if.ld_ready, 0);
        if (mode == 0) check("latency", n - first_n, nh_tot);
      end else begin
        check("csum_err", err, 1);
        check("csum_core_rst", core_rst, 1);
        check("csum_done", done, 0);
      end
      check_mem();
    end
  endtask

  initial begin
    sys_rst        = 1'b1;
    load_start     = 1'b0;
    load_count     = '0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = '0;
    rd_addr        = '0;
    for (int i = 0; i < DEPTH; i++) model_vld[i] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ld_ready", ld_if.ld_ready, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wr_ptr", wr_ptr, 0);
    sys_rst = 1'b0;

    // basic load, valid held high
    halves[0] = 16'h0800; halves[1] = 16'h0005; halves[2] = 16'h1000; halves[3] = 16'h0003;
    run_load(2, 0, 99, 16'h0);
    rd_addr = 4'd1;
    #1;
    check("rd_addr1", rd_data, 32'h10000003);

    // overwrite with other data, then reload the same words with toggling valid
    for (int i = 0; i < 4; i++) halves[i] = 16'($urandom);
    run_load(2, 0, 99, 16'h0);
    halves[0] = 16'h0800; halves[1] = 16'h0005; halves[2] = 16'h1000; halves[3] = 16'h0003;
    run_load(2, 1, 99, 16'h0);
    rd_addr = 4'd0;
    #1;
    check("toggle_mem0", rd_data, 32'h08000005);

    // start-condition table
    vecs[0] = '{5'd0,  1'b0, 1'b1, 1'b1};
    vecs[1] = '{5'd17, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{5'd31, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{5'd1,  1'b1, 1'b0, 1'b1};
    vecs[4] = '{5'd16, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{5'd9,  1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      pulse_start(vecs[k].cnt);
      $display("start count=%0d ready=%0b err=%0b core_rst=%0b", vecs[k].cnt,
               ld_if.ld_ready, err, core_rst);
      check("vec_ready", ld_if.ld_ready, vecs[k].exp_ready);
      check("vec_err", err, vecs[k].exp_err);
      check("vec_core_rst", core_rst, vecs[k].exp_core_rst);
      check("vec_done", done, 0);
      if (vecs[k].exp_ready) check("vec_wr_ptr", wr_ptr, 0);
      repeat (2) @(negedge clk);
      check("vec_ready_hold", ld_if.ld_ready, vecs[k].exp_ready);
      pulse_reset();
    end
    check_mem();

    // full-depth load
    for (int i = 0; i < 32; i++) halves[i] = 16'hA000 + 16'(i);
    run_load(16, 0, 99, 16'h0);
    rd_addr = 4'd15;
    #1;
    check("full_mem15", rd_data, {16'hA01E, 16'hA01F});
    rd_addr = 4'd0;
    #1;
    check("full_mem0", rd_data, {16'hA000, 16'hA001});

    // reset after three half-words of a four-word load
    for (int i = 0; i < 8; i++) halves[i] = 16'($urandom);
    run_load(4, 0, 3, 16'h0);
    pulse_reset();
    check("midrst_ready", ld_if.ld_ready, 0);
    check("midrst_core_rst", core_rst, 1);
    check("midrst_done", done, 0);
    check("midrst_wr_ptr", wr_ptr, 0);
    check_mem();
    halves[0] = 16'h5A5A; halves[1] = 16'hC3C3;
    run_load(1, 0, 99, 16'h0);

`ifdef PGM_CHECKSUM_EN
    halves[0] = 16'h1234; halves[1] = 16'h00FF;
    run_load(1, 0, 99, 16'h0);
    halves[0] = 16'h1234; halves[1] = 16'h00FF;
    run_load(1, 0, 99, 16'h12CB);
`endif

    // random loads
    for (int r = 0; r < 8; r++) begin
      int c;
      logic [15:0] f;
      c = $urandom_range(1, DEPTH);
      for (int i = 0; i < 2 * c; i++) halves[i] = 16'($urandom);
      f = 16'h0;
`ifdef PGM_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) f = 16'($urandom_range(1, 65535));
`endif
      run_load(c, 2, 99, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
